// File: rtl/scan_bus_bridge_pkg.sv
// Shared types and chain field offsets for the scan-driven multi-target bus bridge.
// Command and response words use identical field positions, so one set of offsets serves both.
package scan_bus_bridge_pkg;

    typedef enum logic [1:0] {
        OpNop     = 2'b00,
        OpWrite   = 2'b01,
        OpRead    = 2'b10,
        OpIllegal = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StGap,
        StDone
    } state_e;

    function automatic int unsigned calc_tw(input int unsigned ntgt);
        return (ntgt <= 1) ? 1 : $clog2(ntgt);
    endfunction

    function automatic int unsigned len_lsb();
        return 0;
    endfunction

    function automatic int unsigned data_lsb(input int unsigned lw);
        return lw;
    endfunction

    function automatic int unsigned addr_lsb(input int unsigned dw, input int unsigned lw);
        return dw + lw;
    endfunction

    function automatic int unsigned tgt_lsb(input int unsigned aw, input int unsigned dw,
                                            input int unsigned lw);
        return aw + dw + lw;
    endfunction

    function automatic int unsigned op_lsb(input int unsigned tw, input int unsigned aw,
                                           input int unsigned dw, input int unsigned lw);
        return tw + aw + dw + lw;
    endfunction

    function automatic int unsigned chain_width(input int unsigned tw, input int unsigned aw,
                                                input int unsigned dw, input int unsigned lw);
        return 2 + tw + aw + dw + lw;
    endfunction

endpackage

// File: rtl/scan_bus_bridge_sync.sv
// Multi-flop synchronizer for an asynchronous scan pin with a one-cycle rising-edge pulse.
module scan_sync #(
    parameter int unsigned NSYNC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o
);

    logic [NSYNC-1:0] sync_q, sync_d;
    logic             prev_q, prev_d;

    always_comb begin
        sync_d = NSYNC'({sync_q, async_i});
        prev_d = sync_q[NSYNC-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_o = sync_q[NSYNC-1] & ~prev_q;

endmodule

// File: rtl/scan_bus_bridge.sv
// Scan-chain controlled bridge issuing single or burst read/write commands to one of NTGT
// targets over a shared req/ready bus, with timeout and sticky error status.
module scan_bus_bridge
    import scan_bus_bridge_pkg::*;
#(
    parameter int unsigned NTGT   = 2,
    parameter int unsigned AW     = 11,
    parameter int unsigned DW     = 32,
    parameter int unsigned LW     = 4,
    parameter int unsigned TO_CYC = 64,
    parameter int unsigned NSYNC  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               scan_phi,
    input  logic               scan_phi_bar,
    input  logic               scan_data_in,
    output logic               scan_data_out,
    input  logic               scan_load_chip,
    input  logic               scan_load_chain,
    output logic [NTGT-1:0]    tgt_req,
    output logic               tgt_we,
    output logic [AW-1:0]      tgt_addr,
    output logic [DW-1:0]      tgt_wdata,
    input  logic [NTGT*DW-1:0] tgt_rdata,
    input  logic [NTGT-1:0]    tgt_ready,
    output logic               busy,
    output logic               done
);

    localparam int unsigned TW     = calc_tw(NTGT);
    localparam int unsigned CHAIN  = chain_width(TW, AW, DW, LW);
    localparam int unsigned OP_LO  = op_lsb(TW, AW, DW, LW);
    localparam int unsigned TGT_LO = tgt_lsb(AW, DW, LW);
    localparam int unsigned ADR_LO = addr_lsb(DW, LW);
    localparam int unsigned DAT_LO = data_lsb(LW);
    localparam int unsigned LEN_LO = len_lsb();
    localparam int unsigned TMW    = $clog2(TO_CYC + 1);

    logic phi_rise, phi_bar_rise, chip_rise, chain_rise;

    scan_sync #(.NSYNC(NSYNC)) u_sync_phi (
        .clk     (clk),
        .rst     (rst),
        .async_i (scan_phi),
        .rise_o  (phi_rise)
    );

    scan_sync #(.NSYNC(NSYNC)) u_sync_phi_bar (
        .clk     (clk),
        .rst     (rst),
        .async_i (scan_phi_bar),
        .rise_o  (phi_bar_rise)
    );

    scan_sync #(.NSYNC(NSYNC)) u_sync_chip (
        .clk     (clk),
        .rst     (rst),
        .async_i (scan_load_chip),
        .rise_o  (chip_rise)
    );

    scan_sync #(.NSYNC(NSYNC)) u_sync_chain (
        .clk     (clk),
        .rst     (rst),
        .async_i (scan_load_chain),
        .rise_o  (chain_rise)
    );

    logic [NSYNC-1:0] din_sync_q, din_sync_d;
    logic             in_bit_q, in_bit_d;
    logic [CHAIN-1:0] chain_q, chain_d, resp;

    state_e           state_q, state_d;
    logic             busy_q, busy_d, err_q, err_d, done_q, done_d, we_q, we_d;
    logic [TW-1:0]    tgt_q, tgt_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d, rdata_q, rdata_d, rdata_sel;
    logic [LW-1:0]    len_q, len_d, beat_q, beat_d;
    logic [NTGT-1:0]  req_q, req_d;
    logic [TMW-1:0]   timer_q, timer_d;

    op_e              cmd_op;
    logic [TW-1:0]    cmd_tgt;
    logic             ready_hit;

    function automatic logic [NTGT-1:0] tgt_onehot(input logic [TW-1:0] t);
        logic [NTGT-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < NTGT; i++) begin
            r[i] = (32'(t) == i);
        end
        return r;
    endfunction

    assign cmd_op    = op_e'(chain_q[OP_LO +: 2]);
    assign cmd_tgt   = chain_q[TGT_LO +: TW];
    assign resp      = {busy_q, err_q, tgt_q, addr_q, rdata_q, beat_q};
    // req_q is only ever one-hot on the selected target, so this masks stray readies.
    assign ready_hit = |(tgt_ready & req_q);

    always_comb begin
        rdata_sel = '0;
        for (int unsigned i = 0; i < NTGT; i++) begin
            if (32'(tgt_q) == i) begin
                rdata_sel = tgt_rdata[i*DW +: DW];
            end
        end
    end

    always_comb begin
        din_sync_d = NSYNC'({din_sync_q, scan_data_in});
        in_bit_d   = phi_rise ? din_sync_q[NSYNC-1] : in_bit_q;
        chain_d    = chain_q;
        if (chain_rise) begin
            chain_d = resp;
        end else if (phi_bar_rise) begin
            chain_d = {chain_q[CHAIN-2:0], in_bit_q};
        end
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        err_d   = err_q;
        done_d  = 1'b0;
        we_d    = we_q;
        tgt_d   = tgt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        len_d   = len_q;
        beat_d  = beat_q;
        req_d   = req_q;
        timer_d = timer_q;

        unique case (state_q)
            StIdle: begin
                if (chip_rise) begin
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    we_d    = (cmd_op == OpWrite);
                    tgt_d   = cmd_tgt;
                    addr_d  = chain_q[ADR_LO +: AW];
                    wdata_d = chain_q[DAT_LO +: DW];
                    len_d   = chain_q[LEN_LO +: LW];
                    beat_d  = '0;
                    timer_d = '0;
                    if (cmd_op == OpNop) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else if (cmd_op == OpIllegal || 32'(cmd_tgt) >= NTGT) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        req_d   = tgt_onehot(cmd_tgt);
                        state_d = StIssue;
                    end
                end
            end
            // Issue is the first cycle of a request; ready is honoured from that cycle on.
            StIssue, StWait: begin
                if (ready_hit) begin
                    req_d = '0;
                    if (!we_q) begin
                        rdata_d = rdata_sel;
                    end
                    if (beat_q == len_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StGap;
                    end
                end else if (timer_q == TMW'(TO_CYC - 1)) begin
                    req_d   = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                    state_d = StWait;
                end
            end
            StGap: begin
                addr_d  = addr_q + 1'b1;
                beat_d  = beat_q + 1'b1;
                timer_d = '0;
                req_d   = tgt_onehot(tgt_q);
                state_d = StIssue;
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (chip_rise && busy_q) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            din_sync_q <= '0;
            in_bit_q   <= 1'b0;
            chain_q    <= '0;
            state_q    <= StIdle;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            tgt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            req_q      <= '0;
            timer_q    <= '0;
        end else begin
            din_sync_q <= din_sync_d;
            in_bit_q   <= in_bit_d;
            chain_q    <= chain_d;
            state_q    <= state_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            done_q     <= done_d;
            we_q       <= we_d;
            tgt_q      <= tgt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            req_q      <= req_d;
            timer_q    <= timer_d;
        end
    end

    assign scan_data_out = chain_q[CHAIN-1];
    assign tgt_req       = req_q;
    assign tgt_we        = we_q;
    assign tgt_addr      = addr_q;
    assign tgt_wdata     = wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_scan_bus_bridge.sv
// Directed bench for scan_bus_bridge at default parameters: scan-loads commands, plays the
// targets, and reads responses back through the chain.
module tb_scan_bus_bridge;

    localparam int CHAIN = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scan_phi = 1'b0, scan_phi_bar = 1'b0, scan_data_in = 1'b0;
    logic        scan_load_chip = 1'b0, scan_load_chain = 1'b0;
    logic        scan_data_out;
    logic [1:0]  tgt_req;
    logic        tgt_we;
    logic [10:0] tgt_addr;
    logic [31:0] tgt_wdata;
    logic [63:0] tgt_rdata;
    logic [1:0]  tgt_ready;
    logic        busy, done;
    logic        rdy0 = 1'b0, rdy1_en = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    // Target 1 answers in the request cycle with addr ^ 0xA5A5A5A5; target 0 is bench-driven.
    assign tgt_ready = {rdy1_en & tgt_req[1], rdy0};
    assign tgt_rdata = {({21'b0, tgt_addr} ^ 32'hA5A5A5A5), 32'h0BAD0BAD};

    scan_bus_bridge dut (
        .clk             (clk),
        .rst             (rst),
        .scan_phi        (scan_phi),
        .scan_phi_bar    (scan_phi_bar),
        .scan_data_in    (scan_data_in),
        .scan_data_out   (scan_data_out),
        .scan_load_chip  (scan_load_chip),
        .scan_load_chain (scan_load_chain),
        .tgt_req         (tgt_req),
        .tgt_we          (tgt_we),
        .tgt_addr        (tgt_addr),
        .tgt_wdata       (tgt_wdata),
        .tgt_rdata       (tgt_rdata),
        .tgt_ready       (tgt_ready),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    int          cyc = 0, req0_cnt = 0, req1_cnt = 0, done_cnt = 0, both_cnt = 0;
    logic [1:0]  prev_req = 2'b00;
    logic [10:0] log_addr[$];
    logic [31:0] log_wdata[$];
    logic        log_we[$];
    int          log_cyc[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (tgt_req[0]) req0_cnt <= req0_cnt + 1;
        if (tgt_req[1]) req1_cnt <= req1_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (tgt_req == 2'b11) both_cnt <= both_cnt + 1;
        if (tgt_req != 2'b00 && prev_req == 2'b00) begin
            log_addr.push_back(tgt_addr);
            log_wdata.push_back(tgt_wdata);
            log_we.push_back(tgt_we);
            log_cyc.push_back(cyc);
        end
        prev_req <= tgt_req;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        req0_cnt = 0; req1_cnt = 0; done_cnt = 0;
        log_addr.delete(); log_wdata.delete(); log_we.delete(); log_cyc.delete();
    endtask

    task automatic shift_bit(input logic b);
        scan_data_in = b;
        cycles(2);
        scan_phi = 1'b1;     cycles(6);
        scan_phi = 1'b0;     cycles(6);
        scan_phi_bar = 1'b1; cycles(6);
        scan_phi_bar = 1'b0; cycles(6);
    endtask

    task automatic shift_word(input logic [CHAIN-1:0] w);
        for (int i = CHAIN - 1; i >= 0; i--) shift_bit(w[i]);
    endtask

    task automatic pulse_chip();
        scan_load_chip = 1'b1; cycles(6);
        scan_load_chip = 1'b0; cycles(6);
    endtask

    task automatic pulse_chain();
        scan_load_chain = 1'b1; cycles(6);
        scan_load_chain = 1'b0; cycles(6);
    endtask

    task automatic read_chain(output logic [CHAIN-1:0] w);
        for (int i = CHAIN - 1; i >= 0; i--) begin
            w[i] = scan_data_out;
            shift_bit(1'b0);
        end
    endtask

    task automatic read_resp(output logic [CHAIN-1:0] w);
        pulse_chain();
        read_chain(w);
    endtask

    function automatic logic [CHAIN-1:0] mk(input logic [1:0] hi, input logic t,
                                            input logic [10:0] a, input logic [31:0] d,
                                            input logic [3:0] l);
        return {hi, t, a, d, l};
    endfunction

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 2000) begin @(negedge clk); k++; end
        check_eq({tag, "_idle"}, 64'(busy), 64'd0);
        cycles(4);
    endtask

    task automatic wait_req0(input string tag);
        int k = 0;
        while (!tgt_req[0] && k < 300) begin @(negedge clk); k++; end
        check_eq({tag, "_req_seen"}, 64'(tgt_req[0]), 64'd1);
    endtask

    task automatic respond0(input string tag, input int nbeats, input int delay);
        for (int b = 0; b < nbeats; b++) begin
            wait_req0(tag);
            repeat (delay) @(negedge clk);
            rdy0 = 1'b1;
            @(negedge clk);
            rdy0 = 1'b0;
        end
    endtask

    logic [CHAIN-1:0] r;
    logic [CHAIN-1:0] exp_r;

    initial begin
        cycles(4);
        check_eq("rst_req", 64'(tgt_req), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_sdo", 64'(scan_data_out), 64'd0);
        check_eq("rst_addr", 64'(tgt_addr), 64'd0);
        rst = 1'b0;
        cycles(2);

        // Single write, ready arriving in the fourth request cycle.
        shift_word(mk(2'b01, 1'b0, 11'h010, 32'hDEADBEEF, 4'd0));
        clear_mon();
        fork
            pulse_chip();
            respond0("t1", 1, 3);
        join
        wait_idle("t1");
        check_eq("t1_req0_cycles", 64'(req0_cnt), 64'd4);
        check_eq("t1_req1_cycles", 64'(req1_cnt), 64'd0);
        check_eq("t1_beats", 64'(log_addr.size()), 64'd1);
        check_eq("t1_addr", 64'(log_addr[0]), 64'h010);
        check_eq("t1_we", 64'(log_we[0]), 64'd1);
        check_eq("t1_wdata", 64'(log_wdata[0]), 64'hDEADBEEF);
        check_eq("t1_done", 64'(done_cnt), 64'd1);
        read_resp(r);
        check_eq("t1_resp", 64'(r), 64'(mk(2'b00, 1'b0, 11'h010, 32'h0, 4'd0)));

        // Four-beat read on target 1 wrapping the address; stray ready on target 0.
        shift_word(mk(2'b10, 1'b1, 11'h7FE, 32'h0, 4'd3));
        clear_mon();
        rdy1_en = 1'b1;
        rdy0    = 1'b1;
        pulse_chip();
        wait_idle("t2");
        rdy1_en = 1'b0;
        rdy0    = 1'b0;
        check_eq("t2_beats", 64'(log_addr.size()), 64'd4);
        check_eq("t2_addr0", 64'(log_addr[0]), 64'h7FE);
        check_eq("t2_addr1", 64'(log_addr[1]), 64'h7FF);
        check_eq("t2_addr2", 64'(log_addr[2]), 64'h000);
        check_eq("t2_addr3", 64'(log_addr[3]), 64'h001);
        check_eq("t2_we", 64'(log_we[0]), 64'd0);
        for (int i = 0; i < 3; i++)
            check_eq($sformatf("t2_spacing%0d", i), 64'(log_cyc[i+1] - log_cyc[i]), 64'd2);
        check_eq("t2_req0_cycles", 64'(req0_cnt), 64'd0);
        check_eq("t2_req1_cycles", 64'(req1_cnt), 64'd4);
        read_resp(r);
        check_eq("t2_resp", 64'(r), 64'(mk(2'b00, 1'b1, 11'h001, 32'hA5A5A5A4, 4'd3)));

        // Timeout: target 0 never answers.
        shift_word(mk(2'b01, 1'b0, 11'h020, 32'hCAFEF00D, 4'd2));
        clear_mon();
        pulse_chip();
        wait_idle("t3");
        cycles(20);
        check_eq("t3_req0_cycles", 64'(req0_cnt), 64'd64);
        check_eq("t3_beats", 64'(log_addr.size()), 64'd1);
        check_eq("t3_done", 64'(done_cnt), 64'd1);
        read_resp(r);
        check_eq("t3_resp", 64'(r), 64'(mk(2'b01, 1'b0, 11'h020, 32'hA5A5A5A4, 4'd0)));

        // Illegal op, then NOP clears err.
        shift_word(mk(2'b11, 1'b0, 11'h030, 32'h0, 4'd0));
        clear_mon();
        pulse_chip();
        wait_idle("t4");
        check_eq("t4_no_req", 64'(log_addr.size()), 64'd0);
        check_eq("t4_done", 64'(done_cnt), 64'd1);
        read_resp(r);
        check_eq("t4_err", 64'(r[48]), 64'd1);
        shift_word(mk(2'b00, 1'b0, 11'h000, 32'h0, 4'd0));
        pulse_chip();
        wait_idle("t4n");
        read_resp(r);
        check_eq("t4_nop_err", 64'(r[48]), 64'd0);
        check_eq("t4_nop_busy", 64'(r[49]), 64'd0);

        // Second load_chip mid-burst is ignored but flags err.
        shift_word(mk(2'b01, 1'b0, 11'h100, 32'h12345678, 4'd1));
        clear_mon();
        fork
            begin pulse_chip(); pulse_chip(); end
            respond0("t5", 2, 20);
        join
        wait_idle("t5");
        check_eq("t5_beats", 64'(log_addr.size()), 64'd2);
        check_eq("t5_addr0", 64'(log_addr[0]), 64'h100);
        check_eq("t5_addr1", 64'(log_addr[1]), 64'h101);
        check_eq("t5_wdata1", 64'(log_wdata[1]), 64'h12345678);
        check_eq("t5_done", 64'(done_cnt), 64'd1);
        exp_r = mk(2'b01, 1'b0, 11'h101, 32'hA5A5A5A4, 4'd1);
        read_resp(r);
        check_eq("t5_resp", 64'(r), 64'(exp_r));

        // load_chain and phi_bar rising together: load wins over shift.
        scan_data_in = 1'b1;
        cycles(2);
        scan_phi = 1'b1; cycles(6);
        scan_phi = 1'b0; cycles(6);
        scan_phi_bar = 1'b1; scan_load_chain = 1'b1; cycles(6);
        scan_phi_bar = 1'b0; scan_load_chain = 1'b0; cycles(6);
        read_chain(r);
        check_eq("t5_load_wins", 64'(r), 64'(exp_r));

        // Reset during the wait of beat 2.
        shift_word(mk(2'b01, 1'b0, 11'h200, 32'h55AA55AA, 4'd3));
        clear_mon();
        fork
            begin pulse_chip(); pulse_chain(); end
            begin
                respond0("t6", 1, 30);
                wait_req0("t6b");
                cycles(2);
                check_eq("t6_sdo_busy", 64'(scan_data_out), 64'd1);
                rst = 1'b1;
                @(negedge clk);
                check_eq("t6_req", 64'(tgt_req), 64'd0);
                check_eq("t6_busy", 64'(busy), 64'd0);
                check_eq("t6_sdo", 64'(scan_data_out), 64'd0);
                cycles(2);
                rst = 1'b0;
            end
        join
        cycles(100);
        check_eq("t6_beats", 64'(log_addr.size()), 64'd2);
        read_chain(r);
        check_eq("t6_chain", 64'(r), 64'd0);
        check_eq("onehot", 64'(both_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/scan_bus_bridge.md
Name: scan_bus_bridge

Overview:
Parametrised successor to the single-target scan-to-SRAM/register bridge. Scan pins (two-phase scan_phi/scan_phi_bar, load_chip, load_chain) shift a command word into a chain; load_chip issues it as a single or burst read/write to one of NTGT targets over a shared req/ready bus. load_chain parallel-loads a response word for shift-out.
- New over the previous generation: multi-target select, auto-increment bursts, timeout, and error status.

Parameters:
NTGT, 2, number of target channels (≥1)
AW, 11, target address width
DW, 32, data width
LW, 4, burst length field width (beats = len+1, 1..2^LW)
TO_CYC, 64, cycles to wait for tgt_ready before timeout
NSYNC, 2, synchronizer depth for scan pins
Derived: TW = max(1, $clog2(NTGT)); CHAIN = 2+TW+AW+DW+LW (50 at defaults).

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
scan_phi  in  1  scan master phase, async
scan_phi_bar  in  1  scan slave phase, async
scan_data_in  in  1  serial in
scan_data_out  out  1  serial out, chain MSB, registered
scan_load_chip  in  1  issue command, async
scan_load_chain  in  1  capture response, async
tgt_req  out  NTGT  one-hot request
tgt_we  out  1  1 = write
tgt_addr  out  AW  shared address
tgt_wdata  out  DW  shared write data
tgt_rdata  in  NTGT*DW  per-target read data, target t at [t*DW +: DW]
tgt_ready  in  NTGT  per-target completion
busy  out  1  command in progress
done  out  1  1-cycle pulse at command end

Behaviour:
- Reset: chain, command/response regs, tgt_*, scan_data_out, busy, done all 0; FSM = IDLE; synchronizer flops 0.
- Scan pins pass NSYNC flops plus a rising-edge detector. Each scan phase and load pulse must be ≥ NSYNC+2 clk cycles wide.
- phi rise: latch in_bit <= synced scan_data_in.
- phi_bar rise: chain <= {chain[CHAIN-2:0], in_bit}. Shifting is MSB-first out.
- load_chain rise: chain <= response. If load_chain rise and phi_bar rise occur in the same cycle, the load wins.
- Command layout, MSB→LSB: op[1:0], tgt[TW], addr[AW], wdata[DW], len[LW]. op encoding: 00 NOP, 01 WRITE, 10 READ, 11 illegal.
- Response layout, MSB→LSB: {busy, err}, tgt, cur_addr, rdata, beat_idx.
  - beat_idx = last attempted beat, 0..len.
  - rdata = last read word (unchanged by writes).
- load_chip rise while busy=0: latch the command and set busy. Consequences by command:
  - NOP: clears err, 1 cycle.
  - op 11 or tgt ≥ NTGT: err=1, no request issued.
  - Otherwise: go to ISSUE.
- load_chip rise while busy=1: command ignored, err set sticky.
- err clears only on the next accepted load_chip.
- FSM states: IDLE → ISSUE → WAIT → (GAP → ISSUE)* → DONE → IDLE.
  - ISSUE: drive tgt_req[tgt]=1, tgt_we, tgt_addr=cur_addr, tgt_wdata; timer=0.
  - WAIT: hold all request outputs stable until tgt_ready[tgt]=1 is sampled in the same cycle.
    - Reads: capture rdata in that cycle.
    - Then drop req. If beat_idx==len go to DONE, else go to GAP.
  - GAP: 1 cycle with req low; cur_addr <= cur_addr+1 (wraps mod 2^AW); beat_idx++.
  - Timeout: timer reaching TO_CYC with no ready → drop req, err=1, abort remaining beats, go to DONE.
  - DONE: done=1 for 1 cycle, busy=0, go to IDLE.
- Write bursts repeat the same wdata (fill pattern).
- tgt_ready on non-selected channels, or while req is low, is ignored.
- rst asserted mid-burst: req drops in the next cycle; all state returns to reset values.

Decomposition:
- Package scan_bus_bridge_pkg:
  - op_e (NOP/WRITE/READ/ILLEGAL) and state_e (IDLE/ISSUE/WAIT/GAP/DONE).
  - Localparam field offsets for command and response as functions of TW/AW/DW/LW.
- Sub-module scan_sync: NSYNC flop synchronizer plus rising-edge pulse, synchronous active-high rst. Instantiated 4× (phi, phi_bar, load_chip, load_chain).

Test Plan:
- Shift WRITE, tgt0, addr 0x010, wdata 0xDEADBEEF, len 0; load_chip; ready after 3 cycles → exactly one tgt_req[0] high 4 cycles with we=1, addr 0x010, wdata 0xDEADBEEF; done pulse. load_chain + 50 shifts → busy=0, err=0, addr 0x010, beat_idx 0.
- READ, tgt1, addr 0x7FE, len 3; target1 returns addr^0xA5A5A5A5 with 1-cycle ready → addresses 0x7FE, 0x7FF, 0x000, 0x001 (wrap), one GAP cycle between beats; response rdata 0xA5A5A5A4, beat_idx 3, err 0.
- WRITE, tgt0, len 2; tgt_ready held low → req drops after 64 cycles; done pulses; response err=1, beat_idx 0; no further beats issued.
- tgt field = 1 with NTGT=1 build, or op=11 → no tgt_req ever, err=1. A following NOP → err=0.
- load_chip during a burst → in-flight burst completes unchanged, err=1. Same-cycle load_chain and phi_bar edge → chain equals response, not shifted.
- Assert rst during WAIT of beat 2 → next cycle tgt_req=0, busy=0, chain=0, scan_data_out=0.
